// File: rtl/fir_accum_sequencer.sv
// Accumulates a burst of TAPS unsigned tap products through one shared adder
// and presents the wrapped sum plus a sticky carry-out flag on a valid/ready port.
module fir_accum_sequencer #(
    parameter int WIDTH = 32,
    parameter int TAPS  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [CNT_W-1:0] tap_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TAPS - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum_w;

    assign sum_w = {1'b0, acc_q} + {1'b0, in_data};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = sum_w[WIDTH-1:0];
                    ovf_d = ovf_q | sum_w[WIDTH];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // start arriving with the handshake is deliberately dropped
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_HOLD);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign tap_idx   = cnt_q;

endmodule

// File: tb/tb_fir_accum_sequencer.sv
// Directed bench for fir_accum_sequencer: default build plus a TAPS=1 build.
module tb_fir_accum_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, out_ready;
    logic [31:0] in_data;
    logic        busy, in_ready, out_valid, out_ovf;
    logic [7:0]  tap_idx;
    logic [31:0] out_sum;

    logic        start1, in_valid1, out_ready1;
    logic [31:0] in_data1;
    logic        busy1, in_ready1, out_valid1, out_ovf1;
    logic [7:0]  tap_idx1;
    logic [31:0] out_sum1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_accum_sequencer #(.WIDTH(32), .TAPS(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .tap_idx(tap_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    fir_accum_sequencer #(.WIDTH(32), .TAPS(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .tap_idx(tap_idx1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; in_valid = 0; in_data = '0; out_ready = 1;
        start1 = 0; in_valid1 = 0; in_data1 = '0; out_ready1 = 1;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_tap_idx", tap_idx, 0);
        rst_n = 1'b1;
        tick();

        // Basic sum 1..8
        do_start();
        check("basic_in_ready", in_ready, 1);
        check("basic_busy", busy, 1);
        for (int i = 1; i <= 7; i++) beat(32'(i));
        check("basic_tap7", tap_idx, 7);
        check("basic_not_valid_yet", out_valid, 0);
        beat(32'd8);
        check("basic_out_valid", out_valid, 1);
        check("basic_sum", out_sum, 36);
        check("basic_ovf", out_ovf, 0);
        check("basic_tap_hold", tap_idx, 8);
        tick();
        check("basic_idle_valid", out_valid, 0);
        check("basic_idle_busy", busy, 0);

        // Overflow, then clean burst
        do_start();
        beat(32'hFFFF_FFFF);
        beat(32'h0000_0002);
        for (int i = 0; i < 6; i++) beat(32'h0);
        check("ovf_valid", out_valid, 1);
        check("ovf_sum", out_sum, 1);
        check("ovf_flag", out_ovf, 1);
        tick();
        do_start();
        for (int i = 0; i < 8; i++) beat(32'h1);
        check("ovf2_sum", out_sum, 8);
        check("ovf2_flag", out_ovf, 0);
        tick();

        // Gaps and backpressure
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 8; i++) begin
            beat(32'h10);
            if (i < 7) begin
                tick();
                check("gap_tap_idx", tap_idx, 8'(i + 1));
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", out_sum, 32'h80);
            tick();
        end
        check("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_drop_valid", out_valid, 0);

        // Ignored start pulses
        out_ready = 1'b0;
        do_start();
        for (int i = 0; i < 3; i++) beat(32'h2);
        start = 1'b1;
        beat(32'h2);
        start = 1'b0;
        check("ign_tap4", tap_idx, 4);
        for (int i = 0; i < 4; i++) beat(32'h2);
        check("ign_valid", out_valid, 1);
        start = 1'b1;
        tick();
        check("ign_hold_valid", out_valid, 1);
        check("ign_sum", out_sum, 32'h10);
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("ign_idle_busy", busy, 0);
        tick(); tick();
        check("ign_stay_idle", busy, 0);
        check("ign_sum_kept", out_sum, 32'h10);

        // Reset mid-burst
        do_start();
        for (int i = 0; i < 3; i++) beat(32'h3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", busy, 0);
        check("mrst_in_ready", in_ready, 0);
        check("mrst_tap_idx", tap_idx, 0);
        check("mrst_sum", out_sum, 0);
        check("mrst_valid", out_valid, 0);
        do_start();
        for (int i = 0; i < 8; i++) beat(32'h3);
        check("mrst2_valid", out_valid, 1);
        check("mrst2_sum", out_sum, 32'h18);
        tick();

        // TAPS=1 build
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("t1_in_ready", in_ready1, 1);
        in_valid1 = 1'b1;
        in_data1  = 32'hDEAD_BEEF;
        tick();
        in_valid1 = 1'b0;
        check("t1_valid", out_valid1, 1);
        check("t1_sum", out_sum1, 32'hDEAD_BEEF);
        check("t1_ovf", out_ovf1, 0);
        check("t1_tap", tap_idx1, 1);
        tick();
        check("t1_idle", out_valid1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_accum_sequencer.md
Name: fir_accum_sequencer

Overview:
- Sequences a single shared 32-bit adder to accumulate one FIR output sample from a burst of TAPS tap products.
- Sits between the tap-product multiplier stage and the FIR output register.
- Accepts products over a valid/ready stream, sums them modulo 2^WIDTH and flags any carry-out.
- Presents the result on a valid/ready output port, held until the consumer takes it.

Parameters:
- WIDTH, 32, datapath width of products and sum.
- TAPS, 8, number of products accumulated per output sample (legal range 1 to 256).
- CNT_W, 8, width of the tap counter; must satisfy 2^CNT_W >= TAPS.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
- busy  output  1  high in ACC and HOLD.
- in_valid  input  1  in_data carries a tap product.
- in_data  input  WIDTH  tap product, unsigned.
- in_ready  output  1  high only in ACC.
- tap_idx  output  CNT_W  index of the next product to be accepted (0..TAPS-1).
- out_valid  output  1  out_sum and out_ovf are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  WIDTH  final accumulated sum, modulo 2^WIDTH.
- out_ovf  output  1  sticky: a carry-out occurred on at least one addition in this burst.

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, acc=0, ovf=0, cnt=0. All outputs then read 0: busy, in_ready, out_valid, out_sum, out_ovf, tap_idx.
- Reset mid-burst discards all partial state; no output is produced for the aborted burst.
- States:
  - IDLE: in_ready=0, out_valid=0. start=1 -> ACC; on that edge acc<=0, ovf<=0, cnt<=0.
  - ACC: in_ready=1. A beat is accepted when in_valid & in_ready.
    - On each accepted beat, {carry,acc} <= acc + in_data, with carry-in 0 and a full WIDTH+1 bit result. ovf <= ovf | carry, and cnt <= cnt+1.
    - Cycles with in_valid=0 change nothing; gaps of any length are allowed.
    - When the accepted beat is beat number TAPS-1, the next state is HOLD.
  - HOLD: in_ready=0, out_valid=1. out_sum=acc and out_ovf=ovf, both stable while out_valid=1.
    - out_ready=1 -> IDLE; out_valid drops on the next cycle.
    - out_sum and out_ovf keep their last values in IDLE; they are only meaningful while out_valid=1.
- Latency: out_valid rises on the first clock edge after the last beat is accepted.
- Throughput: at most one beat per cycle. Minimum burst is TAPS+2 cycles from start to return to IDLE, with out_ready tied high.
- tap_idx=cnt at all times. It reads TAPS in HOLD when TAPS < 2^CNT_W.
- start is ignored in ACC and HOLD. A start in the same cycle as the HOLD output handshake is also ignored. A new burst needs a start while in IDLE.
- TAPS=1: the first accepted beat moves the block straight to HOLD. out_sum=in_data and out_ovf=0.
- Wrap-around: the sum wraps modulo 2^WIDTH. ovf is sticky and is never cleared by later additions within the burst.
- No combinational path from inputs to outputs. All outputs come directly from registers or decode of the state register.

Test Plan:
- Basic sum: reset, start, feed 1,2,3,4,5,6,7,8 on consecutive cycles with out_ready=1 -> out_valid rises 1 cycle after the 8th beat; out_sum=36, out_ovf=0; IDLE one cycle later.
- Overflow: feed 0xFFFFFFFF, 0x00000002, then six 0x00000000 -> out_sum=0x00000001, out_ovf=1. A following burst of eight 0x00000001 -> out_sum=8, out_ovf=0 (ovf is cleared at start).
- Gaps and backpressure: interleave in_valid=0 cycles between eight 0x10 beats and hold out_ready=0 for 5 cycles in HOLD:
  - in_ready=0 in HOLD.
  - out_sum=0x80 stays stable for all 5 cycles.
  - out_valid drops one cycle after out_ready=1.
- Ignored start: pulse start during ACC after 3 beats and again during HOLD -> accumulation is unaffected (sum of eight 0x2 is 0x10). The block stays in IDLE afterwards until a fresh start.
- Reset mid-burst: drive rst_n=0 for one edge after 3 accepted beats -> busy=0, in_ready=0, tap_idx=0, out_sum=0. A fresh start with eight 0x3 beats -> out_sum=0x18.
- TAPS=1 build: start, single beat 0xDEADBEEF -> out_valid next cycle, out_sum=0xDEADBEEF, out_ovf=0.
